oled_send_arbiter: RTL and testbench

Shares the single SPI byte sender of the SSD1306 OLED path between two requesters: a command port (init sequence, addressing, contrast) and a pixel port (frame-buffer streaming). It sits between the requesters and the SPI master's `send_en`/`send_busy`/`send_dc`/`send_data` handshake. It sequences one byte at a time, locks the grant for multi-byte bursts, and flags a sender that never acknowledges.

---
 rtl/oled_send_if.sv | 34 +++
 rtl/oled_send_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_oled_send_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_send_if.sv
// Byte handshake bundle between the cmd/pix requesters, the arbiter
// and the SPI byte sender of the SSD1306 path.
interface oled_send_if;
   logic       cmd_valid;
   logic       cmd_dc;
   logic [7:0] cmd_data;
   logic       cmd_last;
   logic       cmd_ready;
   logic       pix_valid;
   logic       pix_dc;
   logic [7:0] pix_data;
   logic       pix_last;
   logic       pix_ready;
   logic       send_en;
   logic       send_dc;
   logic [7:0] send_data;
   logic       send_busy;

   modport master (
      output cmd_valid, cmd_dc, cmd_data, cmd_last,
      output pix_valid, pix_dc, pix_data, pix_last,
      output send_busy,
      input  cmd_ready, pix_ready,
      input  send_en, send_dc, send_data
   );

   modport slave (
      input  cmd_valid, cmd_dc, cmd_data, cmd_last,
      input  pix_valid, pix_dc, pix_data, pix_last,
      input  send_busy,
      output cmd_ready, pix_ready,
      output send_en, send_dc, send_data
   );
endinterface

// File: rtl/oled_send_arbiter.sv
// Two-port byte arbiter for the SSD1306 SPI sender with burst locking.
// OLED_ARB_RR_EN selects round-robin instead of fixed cmd-first priority.
module oled_send_arbiter #(
   parameter int unsigned BUSY_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   oled_send_if.slave bus,
   output logic [1:0] owner,
   output logic       timeout_err
);

   localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_TIMEOUT);

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CMD  = 2'b01;
   localparam logic [1:0] OWN_PIX  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      HOLD
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic          dc_q, dc_d;
   logic [7:0]    data_q, data_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic          pix_rdy_q, pix_rdy_d;
   logic          en_q, en_d;
   logic          take_cmd, take_pix;
   logic          rel;
   logic          pix_win;
   logic          own_cmd_v, own_pix_v;

   assign own_cmd_v = (owner_q == OWN_CMD) & bus.cmd_valid;
   assign own_pix_v = (owner_q == OWN_PIX) & bus.pix_valid;

`ifdef OLED_ARB_RR_EN
   // rr_q = 1: pix has priority on the next contested grant
   logic rr_q, rr_d;

   assign pix_win = bus.pix_valid & (~bus.cmd_valid | rr_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end

   always_comb begin
      rr_d = rr_q;
      if (rel) rr_d = (owner_q == OWN_CMD);
   end
`else
   assign pix_win = bus.pix_valid & ~bus.cmd_valid;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_NONE;
         dc_q      <= 1'b0;
         data_q    <= 8'h00;
         last_q    <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         cmd_rdy_q <= 1'b0;
         pix_rdy_q <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         dc_q      <= dc_d;
         data_q    <= data_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         cmd_rdy_q <= cmd_rdy_d;
         pix_rdy_q <= pix_rdy_d;
         en_q      <= en_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      dc_d      = dc_q;
      data_d    = data_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      cmd_rdy_d = 1'b0;
      pix_rdy_d = 1'b0;
      en_d      = 1'b0;
      take_cmd  = 1'b0;
      take_pix  = 1'b0;
      rel       = 1'b0;

      case (state_q)
         IDLE: begin
            take_pix = pix_win;
            take_cmd = bus.cmd_valid & ~pix_win;
         end
         ISSUE: begin
            en_d    = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.send_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d = 1'b1;
               rel   = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!bus.send_busy) begin
               if (last_q) begin
                  rel = 1'b1;
               end else begin
                  take_cmd = own_cmd_v;
                  take_pix = own_pix_v;
                  if (!own_cmd_v && !own_pix_v) state_d = HOLD;
               end
            end
         end
         HOLD: begin
            take_cmd = own_cmd_v;
            take_pix = own_pix_v;
         end
         default: state_d = IDLE;
      endcase

      if (rel) begin
         owner_d = OWN_NONE;
         state_d = IDLE;
      end

      // grant selection is one-hot by construction
      unique case (1'b1)
         take_cmd: begin
            cmd_rdy_d = 1'b1;
            dc_d      = bus.cmd_dc;
            data_d    = bus.cmd_data;
            last_d    = bus.cmd_last;
            owner_d   = OWN_CMD;
            state_d   = ISSUE;
         end
         take_pix: begin
            pix_rdy_d = 1'b1;
            dc_d      = bus.pix_dc;
            data_d    = bus.pix_data;
            last_d    = bus.pix_last;
            owner_d   = OWN_PIX;
            state_d   = ISSUE;
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready = cmd_rdy_q;
   assign bus.pix_ready = pix_rdy_q;
   assign bus.send_en   = en_q;
   assign bus.send_dc   = dc_q;
   assign bus.send_data = data_q;
   assign owner         = owner_q;
   assign timeout_err   = err_q;

endmodule

// File: tb/tb_oled_send_arbiter.sv
// Scoreboard bench for oled_send_arbiter with a small SPI sender model.
module tb_oled_send_arbiter;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] owner;
   logic       timeout_err;

   oled_send_if bus ();

   oled_send_arbiter #(.BUSY_TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .owner       (owner),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int send_cnt = 0;
   int cmd_rdy_cnt = 0;
   int pix_rdy_cnt = 0;
   logic [10:0] exp_q[$];
   bit spi_dead = 1'b0;

   // SPI sender: busy rises 3 cycles after send_en, stays up 20 cycles
   int dly = 0;
   int len = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.send_busy <= 1'b0;
         dly <= 0;
         len <= 0;
      end else if (spi_dead) begin
         bus.send_busy <= 1'b0;
      end else if (bus.send_en) begin
         dly <= 2;
      end else if (dly != 0) begin
         if (dly == 1) begin
            bus.send_busy <= 1'b1;
            len <= 20;
         end
         dly <= dly - 1;
      end else if (len != 0) begin
         if (len == 1) bus.send_busy <= 1'b0;
         len <= len - 1;
      end
   end

   // scoreboard comparator and handshake rules
   always @(negedge clk) begin
      logic [10:0] e;
      if (bus.cmd_ready) begin
         cmd_rdy_cnt++;
         checks++;
         if (bus.pix_ready || !bus.cmd_valid) begin
            errors++;
            $display("FAIL cmd_ready_rule: pix_ready=%b cmd_valid=%b required 0/1",
                     bus.pix_ready, bus.cmd_valid);
         end
      end
      if (bus.pix_ready) begin
         pix_rdy_cnt++;
         checks++;
         if (!bus.pix_valid) begin
            errors++;
            $display("FAIL pix_ready_rule: pix_valid=%b required 1", bus.pix_valid);
         end
      end
      if (bus.send_en) begin
         send_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_send: got %h/%b/%b, none required",
                     bus.send_data, bus.send_dc, owner);
         end else begin
            e = exp_q.pop_front();
            if ({owner, bus.send_dc, bus.send_data} !== e) begin
               errors++;
               $display("FAIL send_byte: got owner=%b dc=%b data=%h, required owner=%b dc=%b data=%h",
                        owner, bus.send_dc, bus.send_data, e[10:9], e[8], e[7:0]);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      spi_dead = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.pix_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic cmd_send(input logic dc, input logic [7:0] d, input logic last);
      int n = 0;
      bus.cmd_dc = dc;
      bus.cmd_data = d;
      bus.cmd_last = last;
      bus.cmd_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cmd_ready && n < 400);
      checks++;
      if (!bus.cmd_ready) begin
         errors++;
         $display("FAIL cmd_ready_wait: no ready for %h, required a ready pulse", d);
      end
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic pix_send(input logic dc, input logic [7:0] d, input logic last);
      int n = 0;
      bus.pix_dc = dc;
      bus.pix_data = d;
      bus.pix_last = last;
      bus.pix_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.pix_ready && n < 400);
      checks++;
      if (!bus.pix_ready) begin
         errors++;
         $display("FAIL pix_ready_wait: no ready for %h, required a ready pulse", d);
      end
      @(posedge clk);
      #1 bus.pix_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(owner == 2'b00 && !bus.send_busy && exp_q.size() == 0) && n < 1000);
      checks++;
      if (owner !== 2'b00 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_idle: owner=%b pending=%0d, required 00/0", tag, owner, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.cmd_ready, bus.pix_ready, bus.send_en, bus.send_dc,
           bus.send_data, owner, timeout_err} !== 14'd0) begin
         errors++;
         $display("FAIL reset_values: got %b, required all zero",
                  {bus.cmd_ready, bus.pix_ready, bus.send_en, bus.send_dc,
                   bus.send_data, owner, timeout_err});
      end
      do_reset();
   endtask

   task automatic test_single_cmd();
      int s0, c0, p0;
      do_reset();
      s0 = send_cnt; c0 = cmd_rdy_cnt; p0 = pix_rdy_cnt;
      exp_q.push_back({2'b01, 1'b0, 8'hAE});
      bus.cmd_dc = 1'b0;
      bus.cmd_data = 8'hAE;
      bus.cmd_last = 1'b1;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.send_en !== 1'b0) begin
         errors++;
         $display("FAIL single_ready_lat: ready=%b en=%b, required 1/0",
                  bus.cmd_ready, bus.send_en);
      end
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.send_en !== 1'b1 || bus.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_en_lat: en=%b ready=%b, required 1/0",
                  bus.send_en, bus.cmd_ready);
      end
      wait_idle("single");
      checks++;
      if (send_cnt - s0 != 1 || cmd_rdy_cnt - c0 != 1 || pix_rdy_cnt != p0) begin
         errors++;
         $display("FAIL single_counts: en=%0d cmd_rdy=%0d pix_rdy=%0d, required 1/1/0",
                  send_cnt - s0, cmd_rdy_cnt - c0, pix_rdy_cnt - p0);
      end
      checks++;
      if (bus.send_data !== 8'hAE || bus.send_dc !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: data=%h dc=%b, required ae/0",
                  bus.send_data, bus.send_dc);
      end
   endtask

   task automatic test_burst_lock();
      int p0;
      do_reset();
      p0 = pix_rdy_cnt;
      for (int i = 1; i <= 4; i++) exp_q.push_back({2'b10, 1'b1, 8'(i)});
      exp_q.push_back({2'b01, 1'b0, 8'h81});
      fork
         begin
            for (int i = 1; i <= 4; i++) pix_send(1'b1, 8'(i), i == 4);
         end
         begin
            int n = 0;
            while (pix_rdy_cnt < p0 + 1 && n < 400) begin
               @(negedge clk);
               n++;
            end
            cmd_send(1'b0, 8'h81, 1'b1);
            checks++;
            if (pix_rdy_cnt - p0 != 4) begin
               errors++;
               $display("FAIL burst_lock: pix accepted=%0d at cmd grant, required 4",
                        pix_rdy_cnt - p0);
            end
         end
      join
      wait_idle("burst");
   endtask

   task automatic test_arbitration();
      int c0, p0;
      do_reset();
      c0 = cmd_rdy_cnt; p0 = pix_rdy_cnt;
`ifdef OLED_ARB_RR_EN
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({2'b01, 1'b0, 8'h10 + 8'(i)});
         exp_q.push_back({2'b10, 1'b1, 8'h20 + 8'(i)});
      end
`else
      for (int i = 0; i < 4; i++) exp_q.push_back({2'b01, 1'b0, 8'h10 + 8'(i)});
      for (int i = 0; i < 4; i++) exp_q.push_back({2'b10, 1'b1, 8'h20 + 8'(i)});
`endif
      fork
         for (int i = 0; i < 4; i++) cmd_send(1'b0, 8'h10 + 8'(i), 1'b1);
         for (int j = 0; j < 4; j++) pix_send(1'b1, 8'h20 + 8'(j), 1'b1);
      join
      wait_idle("arb");
      checks++;
      if (cmd_rdy_cnt - c0 != 4 || pix_rdy_cnt - p0 != 4) begin
         errors++;
         $display("FAIL arb_counts: cmd=%0d pix=%0d, required 4/4",
                  cmd_rdy_cnt - c0, pix_rdy_cnt - p0);
      end
   endtask

   task automatic test_hold();
      int p0;
      do_reset();
      p0 = pix_rdy_cnt;
      for (int i = 0; i < 4; i++) exp_q.push_back({2'b10, 1'b1, 8'hA0 + 8'(i)});
      exp_q.push_back({2'b01, 1'b0, 8'h81});
      fork
         begin
            int n = 0;
            pix_send(1'b1, 8'hA0, 1'b0);
            pix_send(1'b1, 8'hA1, 1'b0);
            while (!bus.send_busy && n < 50) begin
               @(negedge clk);
               n++;
            end
            while (bus.send_busy && n < 100) begin
               @(negedge clk);
               n++;
            end
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               checks++;
               if (owner !== 2'b10 || bus.cmd_ready !== 1'b0 || bus.send_en !== 1'b0) begin
                  errors++;
                  $display("FAIL hold_gap: owner=%b cmd_ready=%b en=%b, required 10/0/0",
                           owner, bus.cmd_ready, bus.send_en);
               end
            end
            @(posedge clk);
            #1;
            pix_send(1'b1, 8'hA2, 1'b0);
            pix_send(1'b1, 8'hA3, 1'b1);
         end
         begin
            int n = 0;
            while (pix_rdy_cnt < p0 + 1 && n < 400) begin
               @(negedge clk);
               n++;
            end
            cmd_send(1'b0, 8'h81, 1'b1);
            checks++;
            if (pix_rdy_cnt - p0 != 4) begin
               errors++;
               $display("FAIL hold_lock: pix accepted=%0d at cmd grant, required 4",
                        pix_rdy_cnt - p0);
            end
         end
      join
      wait_idle("hold");
   endtask

   task automatic test_timeout();
      do_reset();
      spi_dead = 1'b1;
      exp_q.push_back({2'b01, 1'b0, 8'h55});
      cmd_send(1'b0, 8'h55, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.send_en !== 1'b1) begin
         errors++;
         $display("FAIL to_en: en=%b, required 1", bus.send_en);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL to_early: timeout_err=%b at 15, required 0", timeout_err);
      end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b1 || owner !== 2'b00) begin
         errors++;
         $display("FAIL to_set: timeout_err=%b owner=%b at 16, required 1/00",
                  timeout_err, owner);
      end
      spi_dead = 1'b0;
      exp_q.push_back({2'b10, 1'b1, 8'h77});
      pix_send(1'b1, 8'h77, 1'b1);
      wait_idle("to");
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL to_sticky: timeout_err=%b, required 1", timeout_err);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      do_reset();
      exp_q.push_back({2'b01, 1'b1, 8'h3C});
      cmd_send(1'b1, 8'h3C, 1'b0);
      while (!bus.send_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (owner !== 2'b01 || bus.send_data !== 8'h3C) begin
         errors++;
         $display("FAIL mid_pre: owner=%b data=%h, required 01/3c", owner, bus.send_data);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.cmd_ready, bus.pix_ready, bus.send_en, bus.send_dc,
           bus.send_data, owner, timeout_err} !== 14'd0) begin
         errors++;
         $display("FAIL mid_reset: got %b, required all zero",
                  {bus.cmd_ready, bus.pix_ready, bus.send_en, bus.send_dc,
                   bus.send_data, owner, timeout_err});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.push_back({2'b01, 1'b0, 8'hA5});
      cmd_send(1'b0, 8'hA5, 1'b1);
      wait_idle("mid");
      checks++;
      if (bus.send_data !== 8'hA5) begin
         errors++;
         $display("FAIL mid_after: data=%h, required a5", bus.send_data);
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_dc = 1'b0;
      bus.cmd_data = 8'h00;
      bus.cmd_last = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_dc = 1'b0;
      bus.pix_data = 8'h00;
      bus.pix_last = 1'b0;
      test_reset();
      test_single_cmd();
      test_burst_lock();
      test_arbitration();
      test_hold();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
